// File: rtl/aqp_sysctrl_gen.sv
// aqp_sysctrl_gen: system control block. Sequences the external and internal
// resets, generates the expansion-bus phi clock with its clock-enable, and
// provides NUM_CH programmable clock-enable channels.
// Optional watchdog: define AQP_SYSCTRL_WATCHDOG_EN to build it in.
module aqp_sysctrl_gen #(
  parameter int unsigned EXT_RST_BITS = 23,
  parameter int unsigned INT_RST_BITS = 5,
  parameter int unsigned PHI_HALF     = 4,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned DIV_W        = 8,
  parameter int unsigned WDT_BITS     = 24
) (
  input  logic                    sysclk,
  input  logic                    reset_n,
  input  logic                    reset_req,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic                    ext_reset,
  output logic                    reset,
  output logic                    reset_done,
  output logic                    ebus_phi,
  output logic                    ebus_phi_clken,
  output logic [NUM_CH-1:0]       ch_clken,
  input  logic                    wdt_kick,
  output logic                    wdt_fired
);

  localparam int unsigned PW = (PHI_HALF > 1) ? $clog2(PHI_HALF) : 1;
  localparam logic [EXT_RST_BITS-1:0] EXT_LAST = EXT_RST_BITS'((1 << (EXT_RST_BITS - 1)) - 1);
  localparam logic [INT_RST_BITS-1:0] INT_LAST = INT_RST_BITS'((1 << (INT_RST_BITS - 1)) - 1);
  localparam logic [PW-1:0]           PHI_LAST = PW'(PHI_HALF - 1);

  typedef enum logic [1:0] {
    ST_EXT,
    ST_SYNC,
    ST_INT,
    ST_RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [EXT_RST_BITS-1:0] ext_cnt_q, ext_cnt_d;
  logic [INT_RST_BITS-1:0] int_cnt_q, int_cnt_d;
  logic                    sync_cnt_q, sync_cnt_d;
  logic                    done_q, done_d;
  logic                    restart;

  logic [PW-1:0]           phi_cnt_q, phi_cnt_d;
  logic                    phi_int_q, phi_int_d;
  logic                    phi_clken_q, phi_clken_d;
  logic                    phi_out_q, phi_out_d;
  logic                    phi_tc;

  logic [NUM_CH-1:0][DIV_W-1:0] ch_cnt_q, ch_cnt_d;
  logic [NUM_CH-1:0]            ch_clken_q, ch_clken_d;

`ifdef AQP_SYSCTRL_WATCHDOG_EN
  logic [WDT_BITS-1:0] wdt_cnt_q, wdt_cnt_d;
  logic                wdt_fired_q, wdt_fired_d;
  logic                wdt_fire;

  assign wdt_fire = (state_q == ST_RUN) && (wdt_cnt_q == '1);
  assign restart  = reset_req | wdt_fire;

  // Watchdog counts RUN cycles since entry or last kick; expiry restarts the sequence
  always_comb begin
    wdt_cnt_d   = '0;
    wdt_fired_d = wdt_fired_q;
    if ((state_q == ST_RUN) && !wdt_kick && !wdt_fire) begin
      wdt_cnt_d = wdt_cnt_q + WDT_BITS'(1);
    end
    if (wdt_fire) begin
      wdt_fired_d = 1'b1;
    end else if (reset_req && (state_q == ST_RUN)) begin
      wdt_fired_d = 1'b0;
    end
  end

  // Watchdog registers
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      wdt_cnt_q   <= '0;
      wdt_fired_q <= 1'b0;
    end else begin
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_fired_q <= wdt_fired_d;
    end
  end

  assign wdt_fired = wdt_fired_q;
`else
  logic unused_wdt;

  assign unused_wdt = wdt_kick ^ WDT_BITS[0];
  assign restart    = reset_req;
  assign wdt_fired  = 1'b0;
`endif

  // Reset sequencer next-state: EXT -> SYNC (2 cycles) -> INT -> RUN, restart wins
  always_comb begin
    state_d    = state_q;
    ext_cnt_d  = '0;
    int_cnt_d  = '0;
    sync_cnt_d = 1'b0;
    if (restart) begin
      state_d = ST_EXT;
    end else begin
      unique case (state_q)
        ST_EXT: begin
          if (ext_cnt_q == EXT_LAST) state_d = ST_SYNC;
          else ext_cnt_d = ext_cnt_q + EXT_RST_BITS'(1);
        end
        ST_SYNC: begin
          if (sync_cnt_q) state_d = ST_INT;
          else sync_cnt_d = 1'b1;
        end
        ST_INT: begin
          if (int_cnt_q == INT_LAST) state_d = ST_RUN;
          else int_cnt_d = int_cnt_q + INT_RST_BITS'(1);
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: state_d = ST_EXT;
      endcase
    end
    done_d = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  // Reset sequencer registers
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EXT;
      ext_cnt_q  <= '0;
      int_cnt_q  <= '0;
      sync_cnt_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ext_cnt_q  <= ext_cnt_d;
      int_cnt_q  <= int_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      done_q     <= done_d;
    end
  end

  assign ext_reset  = (state_q == ST_EXT);
  assign reset      = (state_q != ST_RUN);
  assign reset_done = done_q;

  // Phi divider: clken is registered so it coincides with the internal phi toggle
  always_comb begin
    phi_tc      = (phi_cnt_q == PHI_LAST);
    phi_cnt_d   = phi_tc ? '0 : phi_cnt_q + PW'(1);
    phi_int_d   = phi_int_q ^ phi_tc;
    phi_clken_d = phi_tc;
    phi_out_d   = phi_int_q;
  end

  // Phi registers, free-running from reset_n only
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      phi_cnt_q   <= '0;
      phi_int_q   <= 1'b0;
      phi_clken_q <= 1'b0;
      phi_out_q   <= 1'b0;
    end else begin
      phi_cnt_q   <= phi_cnt_d;
      phi_int_q   <= phi_int_d;
      phi_clken_q <= phi_clken_d;
      phi_out_q   <= phi_out_d;
    end
  end

  assign ebus_phi       = phi_out_q;
  assign ebus_phi_clken = phi_clken_q;

  // Channel dividers: >= compare lets a lowered divide value take effect at once
  always_comb begin
    ch_cnt_d   = '0;
    ch_clken_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!reset && ch_en[i]) begin
        if (ch_cnt_q[i] >= ch_div[i*DIV_W +: DIV_W]) ch_clken_d[i] = 1'b1;
        else ch_cnt_d[i] = ch_cnt_q[i] + DIV_W'(1);
      end
    end
  end

  // Channel registers
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      ch_cnt_q   <= '0;
      ch_clken_q <= '0;
    end else begin
      ch_cnt_q   <= ch_cnt_d;
      ch_clken_q <= ch_clken_d;
    end
  end

  assign ch_clken = ch_clken_q;

endmodule
